// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl
// Data-memory bus controller between the processor's memory stage and a
// single-port data memory bus whose ack latency is variable. Each memory-stage
// load/store becomes one bus transaction. Busy stalls the pipeline until the
// transaction completes. Word and byte accesses are handled by lane selection,
// byte-enable generation and sign extension. Misaligned word accesses and bus
// timeouts set a sticky Error flag.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   ReqValid/ReqWrite/ReqByte/ReqAddr/ReqWData   memory-stage request
//   Busy              stall request to the hazard unit
//   RspValid/RspRData one-cycle response pulse and formatted load data
//   Error             sticky misalignment/timeout flag
//   BusReq/BusWe/BusAddr/BusBe/BusWData          bus request side
//   BusAck/BusRData   bus completion and read data
module dmem_bus_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ReqValid,
  input  logic                 ReqWrite,
  input  logic                 ReqByte,
  input  logic [WORD_SIZE-1:0] ReqAddr,
  input  logic [WORD_SIZE-1:0] ReqWData,
  output logic                 Busy,
  output logic                 RspValid,
  output logic [WORD_SIZE-1:0] RspRData,
  output logic                 Error,
  output logic                 BusReq,
  output logic                 BusWe,
  output logic [WORD_SIZE-1:0] BusAddr,
  output logic [3:0]           BusBe,
  output logic [WORD_SIZE-1:0] BusWData,
  input  logic                 BusAck,
  input  logic [WORD_SIZE-1:0] BusRData
);

  // TIMEOUT >= 2, so the counter is at least one bit wide.
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_r;
  state_e                 stateNext_s;
  logic                   captWrite_r;
  logic                   captByte_r;
  logic [WORD_SIZE-1:0]   captAddr_r;
  logic [WORD_SIZE-1:0]   captWData_r;
  logic [CW-1:0]          cnt_r;
  logic [WORD_SIZE-1:0]   rspData_r;
  logic                   error_r;
  logic                   accept_s;
  logic                   misalign_s;
  logic                   timeout_s;

  // One-hot byte enable for a byte lane.
  function automatic logic [3:0] laneBe(input logic [1:0] lane);
    logic [3:0] be;
    case (lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0010;
      2'd2:    be = 4'b0100;
      2'd3:    be = 4'b1000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Response data for an acked transaction: 0 for stores, the raw word for
  // word loads, the sign-extended addressed lane for byte loads.
  function automatic logic [31:0] formatLoad(input logic        isWrite,
                                             input logic        isByte,
                                             input logic [1:0]  lane,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [31:0] res;
    b = rdata[{lane, 3'b000} +: 8];
    if (isWrite) begin
      res = 32'h0000_0000;
    end else if (isByte) begin
      res = {{24{b[7]}}, b};
    end else begin
      res = rdata;
    end
    return res;
  endfunction

  // Request qualification in IDLE; timeout detection in BUS.
  always_comb begin
    accept_s   = 1'b0;
    misalign_s = 1'b0;
    timeout_s  = 1'b0;
    if (state_r == IDLE && ReqValid) begin
      accept_s   = ReqByte || (ReqAddr[1:0] == 2'b00);
      misalign_s = !ReqByte && (ReqAddr[1:0] != 2'b00);
    end else begin
      accept_s   = 1'b0;
      misalign_s = 1'b0;
    end
    if (state_r == BUS && !BusAck && cnt_r == CNT_LAST) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          stateNext_s = BUS;
        end else if (misalign_s) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = IDLE;
        end
      end
      BUS: begin
        // An ack in the limit cycle wins over the timeout.
        if (BusAck || timeout_s) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = BUS;
        end
      end
      DONE:    stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // Request capture, timeout counter, response data and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      captWrite_r <= 1'b0;
      captByte_r  <= 1'b0;
      captAddr_r  <= '0;
      captWData_r <= '0;
      cnt_r       <= '0;
      rspData_r   <= '0;
      error_r     <= 1'b0;
    end else begin
      if (state_r == IDLE && ReqValid) begin
        captWrite_r <= ReqWrite;
        captByte_r  <= ReqByte;
        captAddr_r  <= ReqAddr;
        captWData_r <= ReqWData;
        cnt_r       <= '0;
      end
      if (misalign_s || timeout_s) begin
        error_r   <= 1'b1;
        rspData_r <= '0;
      end else if (state_r == BUS && BusAck) begin
        rspData_r <= formatLoad(captWrite_r, captByte_r, captAddr_r[1:0], BusRData);
      end
      if (state_r == BUS && !BusAck && !timeout_s) begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // FSM outputs; bus signals come straight from captured registers.
  always_comb begin
    Busy     = 1'b0;
    RspValid = 1'b0;
    BusReq   = 1'b0;
    BusWe    = 1'b0;
    BusAddr  = '0;
    BusBe    = 4'b0000;
    BusWData = '0;
    case (state_r)
      IDLE: begin
        // Gate with rst so the stall drops while reset is asserted.
        Busy = ReqValid && rst;
      end
      BUS: begin
        Busy    = 1'b1;
        BusReq  = 1'b1;
        BusWe   = captWrite_r;
        BusAddr = {captAddr_r[WORD_SIZE-1:2], 2'b00};
        if (captByte_r) begin
          BusBe    = laneBe(captAddr_r[1:0]);
          BusWData = {4{captWData_r[7:0]}};
        end else begin
          BusBe    = 4'b1111;
          BusWData = captWData_r;
        end
      end
      DONE: begin
        RspValid = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

  assign RspRData = rspData_r;
  assign Error    = error_r;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
module tb_dmem_bus_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqWrite = 1'b0;
  logic        ReqByte = 1'b0;
  logic [31:0] ReqAddr = 32'h0;
  logic [31:0] ReqWData = 32'h0;
  logic        Busy;
  logic        RspValid;
  logic [31:0] RspRData;
  logic        Error;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [3:0]  BusBe;
  logic [31:0] BusWData;
  logic        BusAck = 1'b0;
  logic [31:0] BusRData = 32'h0;

  int nAsserts = 0;
  int nFail = 0;

  // Reference state kept by the bench.
  logic        modelError = 1'b0;
  logic [31:0] modelRsp = 32'h0;

  dmem_bus_ctrl #(.WORD_SIZE(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqByte(ReqByte),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .Busy(Busy), .RspValid(RspValid), .RspRData(RspRData), .Error(Error),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusBe(BusBe),
    .BusWData(BusWData), .BusAck(BusAck), .BusRData(BusRData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One complete request. ackDelay = number of BUS cycles before the ack
  // cycle; ackDelay >= TO means the bus never acks.
  task automatic doReq(input logic wr, input logic by, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ackDelay,
                       input logic [31:0] rdata);
    logic        mis;
    logic [31:0] expBe;
    logic [31:0] expWd;
    logic [31:0] expRsp;
    int          lane;
    int          b;
    int          busCycles;
    logic        acked;
    mis  = !by && (addr % 4 != 0);
    lane = addr % 4;
    expBe = by ? (32'd1 << lane) : 32'hF;
    expWd = by ? (wdata & 32'hFF) * 32'h0101_0101 : wdata;
    b = (rdata >> (8 * lane)) & 32'hFF;
    if (wr) expRsp = 32'h0;
    else if (by) expRsp = (b >= 128) ? (32'(b) | 32'hFFFF_FF00) : 32'(b);
    else expRsp = rdata;

    ReqValid = 1'b1; ReqWrite = wr; ReqByte = by; ReqAddr = addr; ReqWData = wdata;
    #1;
    check("busy_req_cycle", 32'(Busy), 32'd1);
    check("busreq_req_cycle", 32'(BusReq), 32'd0);
    nextCycle();
    acked = 1'b0;
    busCycles = 0;
    if (mis) begin
      modelError = 1'b1;
      modelRsp = 32'h0;
    end else begin
      for (int k = 0; k < TO; k++) begin
        busCycles++;
        check("bus_busreq", 32'(BusReq), 32'd1);
        check("bus_busy", 32'(Busy), 32'd1);
        check("bus_we", 32'(BusWe), 32'(wr));
        check("bus_addr", BusAddr, addr & 32'hFFFF_FFFC);
        check("bus_be", 32'(BusBe), expBe);
        if (wr) check("bus_wdata", BusWData, expWd);
        if (k == ackDelay) begin
          BusAck = 1'b1;
          BusRData = rdata;
          acked = 1'b1;
        end
        nextCycle();
        BusAck = 1'b0;
        BusRData = $urandom;
        if (acked) break;
      end
      if (acked) modelRsp = expRsp;
      else begin
        modelError = 1'b1;
        modelRsp = 32'h0;
      end
      check("bus_cycles", 32'(busCycles), (ackDelay >= TO) ? 32'(TO) : 32'(ackDelay + 1));
    end
    // DONE cycle: ReqValid is still held and must be ignored.
    check("done_rspvalid", 32'(RspValid), 32'd1);
    check("done_rspdata", RspRData, modelRsp);
    check("done_busy", 32'(Busy), 32'd0);
    check("done_busreq", 32'(BusReq), 32'd0);
    check("done_error", 32'(Error), 32'(modelError));
    ReqValid = 1'b0;
    nextCycle();
    check("idle_rspvalid", 32'(RspValid), 32'd0);
    check("idle_rsphold", RspRData, modelRsp);
    check("idle_busy", 32'(Busy), 32'd0);
  endtask

  initial begin
    // Reset state.
    ReqValid = 1'b1;
    #3;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_busreq", 32'(BusReq), 32'd0);
    check("rst_rspvalid", 32'(RspValid), 32'd0);
    check("rst_rspdata", RspRData, 32'h0);
    check("rst_error", 32'(Error), 32'd0);
    ReqValid = 1'b0;
    nextCycle();
    rst = 1'b1;
    nextCycle();
    check("idle_noreq_busy", 32'(Busy), 32'd0);

    // Directed cases.
    doReq(1'b0, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    doReq(1'b0, 1'b1, 32'h103, 32'h0, 0, 32'h80123456);
    doReq(1'b0, 1'b1, 32'h102, 32'h0, 0, 32'h80123456);
    doReq(1'b1, 1'b1, 32'h201, 32'h000000AB, 0, 32'h0);
    doReq(1'b1, 1'b0, 32'h304, 32'h12345678, 2, 32'h0);
    check("error_clean", 32'(Error), 32'd0);
    doReq(1'b0, 1'b0, 32'h400, 32'h0, TO - 1, 32'hCAFEF00D);
    check("ack_at_limit_no_error", 32'(Error), 32'd0);
    doReq(1'b0, 1'b0, 32'h500, 32'h0, 100, 32'h0);
    doReq(1'b0, 1'b0, 32'h104, 32'h0, 0, 32'h11112222);
    check("error_sticky", 32'(Error), 32'd1);
    doReq(1'b0, 1'b0, 32'h102, 32'h0, 0, 32'h0);

    // Randomized requests, back-to-back or with idle gaps.
    for (int i = 0; i < 40; i++) begin
      logic        wr;
      logic        by;
      logic [31:0] addr;
      int          dly;
      wr = 1'($urandom_range(0, 1));
      by = 1'($urandom_range(0, 1));
      addr = $urandom & 32'h0000_FFFF;
      if (!by && $urandom_range(0, 7) != 0) addr = addr & 32'hFFFF_FFFC;
      dly = ($urandom_range(0, 9) == 0) ? TO + 3 : int'($urandom_range(0, 3));
      doReq(wr, by, addr, $urandom, dly, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        nextCycle();
        check("gap_busy", 32'(Busy), 32'd0);
      end
    end

    // Asynchronous reset in the middle of a bus transaction.
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqByte = 1'b0; ReqAddr = 32'h600;
    nextCycle();
    check("pre_rst_busreq", 32'(BusReq), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_busreq", 32'(BusReq), 32'd0);
    check("async_rst_busy", 32'(Busy), 32'd0);
    check("async_rst_error", 32'(Error), 32'd0);
    modelError = 1'b0;
    modelRsp = 32'h0;
    #1;
    rst = 1'b1;
    ReqValid = 1'b0;
    nextCycle();
    check("post_rst_rspvalid", 32'(RspValid), 32'd0);
    check("post_rst_busreq", 32'(BusReq), 32'd0);
    doReq(1'b0, 1'b1, 32'h701, 32'h0, 1, 32'h00007F00);
    check("post_rst_error", 32'(Error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Data-memory bus controller between the processor's memory stage and an external single-port data memory bus with variable ack latency.
- Turns one memory-stage load/store into one bus transaction and holds the pipeline with Busy until the transaction completes.
- Handles word and byte (LoadByte) accesses: lane selection, sign extension, byte-enable generation.
- Detects misaligned word accesses and bus timeouts; reports them on a sticky error flag.

Parameters:
- WORD_SIZE, 32, data/address width; the design supports only 32.
- TIMEOUT, 16, maximum number of BUS-state cycles without BusAck before abort; minimum value 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ReqValid  in  1  memory stage holds a load or store this cycle.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqByte  in  1  1 = byte access (LoadByte / store-byte), 0 = word access.
- ReqAddr  in  WORD_SIZE  byte address (ALUResultM).
- ReqWData  in  WORD_SIZE  store data (WriteDataM); byte stores use bits [7:0].
- Busy  out  1  stall request to the hazard unit; freezes all stages up to and including memory.
- RspValid  out  1  one-cycle pulse: RspRData is valid for the current request.
- RspRData  out  WORD_SIZE  formatted load data; 0 for stores and for errored requests.
- Error  out  1  sticky flag: a misaligned access or timeout has occurred.
- BusReq  out  1  bus request.
- BusWe  out  1  bus write enable.
- BusAddr  out  WORD_SIZE  word-aligned address; bits [1:0] are always 0.
- BusBe  out  4  byte enables.
- BusWData  out  WORD_SIZE  bus write data.
- BusAck  in  1  bus completion, sampled while BusReq=1.
- BusRData  in  WORD_SIZE  read data, valid in the same cycle as BusAck.

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0, including BusReq, Busy, RspValid, RspRData, Error; timeout counter cleared.
  - Reset during BUS drops BusReq immediately and abandons the transaction; no response is produced.
- States: IDLE, BUS, DONE.
- IDLE
  - Busy = ReqValid (combinational).
  - On ReqValid, capture write, byte, addr and wdata into internal registers.
  - Aligned access (ReqByte=1, or ReqAddr[1:0]=0): go to BUS and clear the counter.
  - Misaligned word access: no bus transaction; set Error; load 0 into the response data; go to DONE.
- BUS
  - Busy=1 and BusReq=1. BusWe, BusAddr, BusBe and BusWData are driven from the captured registers and stay stable until ack.
  - BusAddr = {addr[31:2], 2'b00}.
  - Word access: BusBe = 4'b1111; BusWData = wdata.
  - Byte access: BusBe = one-hot at lane addr[1:0]; BusWData = wdata[7:0] replicated in all four lanes.
  - On BusAck, load the response data and go to DONE:
    - Word load: BusRData.
    - Byte load: byte at lane addr[1:0], sign-extended to 32 bits.
    - Store: 0.
  - Without ack, the counter increments each cycle. When the counter reaches TIMEOUT-1 with no ack:
    - drop BusReq, set Error, response data 0, go to DONE.
  - BusAck in the same cycle the counter hits its limit: the ack wins, normal completion, Error unchanged.
- DONE
  - Busy=0 and RspValid=1 for exactly one cycle; RspRData holds the response.
  - The pipeline advances on this edge. ReqValid is ignored in DONE because it still belongs to the completed request.
  - Always return to IDLE.
- Latency:
  - Accepted aligned request: Busy high from the request cycle through the ack cycle; RspValid one cycle after ack.
  - Ack in the first BUS cycle gives a total of 3 cycles from request to RspValid.
- RspRData holds its value until the next DONE. Error clears only on reset.
- Back-to-back requests: the next instruction presents in the cycle after DONE and is accepted in IDLE, so there is no bubble beyond DONE.

Test Plan:
- Word load at ReqAddr=0x100; ack after 2 BUS cycles with BusRData=0xDEADBEEF -> BusAddr=0x100, BusBe=4'b1111, BusWe=0; RspValid one cycle after ack with RspRData=0xDEADBEEF; Busy high for 3 cycles.
- Byte load at ReqAddr=0x103; BusRData=0x80123456 with immediate ack -> BusAddr=0x100, BusBe=4'b1000, RspRData=0xFFFFFF80. Repeat at 0x102 -> RspRData=0x00000012.
- Byte store at ReqAddr=0x201 with ReqWData=0x000000AB -> BusWe=1, BusAddr=0x200, BusBe=4'b0010, BusWData=0xABABABAB; RspRData=0.
- BusAck never asserted, TIMEOUT=16 -> BusReq high for exactly 16 cycles, then drops; Error=1; RspValid pulse with RspRData=0; Error stays 1 across later good transactions.
- Word load at ReqAddr=0x102 -> BusReq never asserts; RspValid one cycle later with RspRData=0; Error=1.
- rst pulled low while in BUS -> BusReq, Busy and Error go to 0 without waiting for a clock edge; no RspValid; the next request after rst release completes normally.
